// File: rtl/mem_access.sv
// Load/store stage: one bus transaction per op, IDLE -> BUSY -> DONE, 3 cycles minimum.
// Holds the pipeline through stallreq while the bus cycle is outstanding, and releases it when the ack arrives.
module mem_access #(
  parameter int DW  = 32,
  parameter int RAW = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [RAW-1:0] mem_wd_i,
  input  logic           mem_wreg_i,
  input  logic [DW-1:0]  mem_wdata_i,
  input  logic [3:0]     mem_op_i,
  input  logic [DW-1:0]  mem_addr_i,
  input  logic [DW-1:0]  mem_sdata_i,
  input  logic           flush,
  output logic [RAW-1:0] mem_wd,
  output logic           mem_wreg,
  output logic [DW-1:0]  mem_wdata,
  output logic           stallreq,
  output logic           addr_err,
  output logic           dbus_req,
  output logic           dbus_we,
  output logic [DW-1:0]  dbus_addr,
  output logic [3:0]     dbus_sel,
  output logic [DW-1:0]  dbus_wdata,
  input  logic [DW-1:0]  dbus_rdata,
  input  logic           dbus_ack
);

  localparam logic [3:0] OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4,
                         OP_LW = 4'd5, OP_SB  = 4'd6, OP_SH = 4'd7, OP_SW  = 4'd8;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;

  logic          is_load, is_store, is_mem, misalign, launch;
  logic [1:0]    size;  // 0 byte, 1 half, 2 word
  logic [3:0]    sel_c;
  logic [DW-1:0] swdata_c;
  logic [3:0]    op_q;
  logic [1:0]    off_q;
  logic [7:0]    rbyte;
  logic [15:0]   rhalf;
  logic [DW-1:0] ld_ext, result;
  logic          cancel;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    size     = 2'd0;
    case (mem_op_i)
      OP_LB, OP_LBU: begin is_load  = 1'b1; size = 2'd0; end
      OP_LH, OP_LHU: begin is_load  = 1'b1; size = 2'd1; end
      OP_LW:         begin is_load  = 1'b1; size = 2'd2; end
      OP_SB:         begin is_store = 1'b1; size = 2'd0; end
      OP_SH:         begin is_store = 1'b1; size = 2'd1; end
      OP_SW:         begin is_store = 1'b1; size = 2'd2; end
      default:       ;
    endcase
    is_mem   = is_load | is_store;
    misalign = is_mem & (((size == 2'd1) & mem_addr_i[0]) |
                         ((size == 2'd2) & (mem_addr_i[1:0] != 2'b00)));
    launch   = (state == IDLE) & is_mem & ~misalign & ~flush & ~rst;

    // Lane 0 of the bus is the most significant byte.
    case (size)
      2'd0:    sel_c = 4'b1000 >> mem_addr_i[1:0];
      2'd1:    sel_c = mem_addr_i[1] ? 4'b0011 : 4'b1100;
      default: sel_c = 4'b1111;
    endcase
    case (size)
      2'd0:    swdata_c = DW'({4{mem_sdata_i[7:0]}});
      2'd1:    swdata_c = DW'({2{mem_sdata_i[15:0]}});
      default: swdata_c = mem_sdata_i;
    endcase
  end

  always_comb begin
    case (off_q)
      2'd0:    rbyte = dbus_rdata[31:24];
      2'd1:    rbyte = dbus_rdata[23:16];
      2'd2:    rbyte = dbus_rdata[15:8];
      default: rbyte = dbus_rdata[7:0];
    endcase
    rhalf = off_q[1] ? dbus_rdata[15:0] : dbus_rdata[31:16];
    case (op_q)
      OP_LB:   ld_ext = {{(DW-8){rbyte[7]}}, rbyte};
      OP_LBU:  ld_ext = {{(DW-8){1'b0}}, rbyte};
      OP_LH:   ld_ext = {{(DW-16){rhalf[15]}}, rhalf};
      OP_LHU:  ld_ext = {{(DW-16){1'b0}}, rhalf};
      default: ld_ext = dbus_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = BUSY;
      BUSY:    if (dbus_ack) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= '0;
      dbus_sel   <= 4'b0000;
      dbus_wdata <= '0;
      op_q       <= 4'd0;
      off_q      <= 2'd0;
      result     <= '0;
      cancel     <= 1'b0;
    end else begin
      if (launch) begin
        dbus_req   <= 1'b1;
        dbus_we    <= is_store;
        dbus_addr  <= {mem_addr_i[DW-1:2], 2'b00};
        dbus_sel   <= sel_c;
        dbus_wdata <= swdata_c;
        op_q       <= mem_op_i;
        off_q      <= mem_addr_i[1:0];
      end else if ((state == BUSY) && dbus_ack) begin
        dbus_req <= 1'b0;
        result   <= ld_ext;
      end
      // A flush mid-transaction only suppresses the write-back; the bus cycle still completes.
      if (state == DONE)                 cancel <= 1'b0;
      else if ((state == BUSY) && flush) cancel <= 1'b1;
    end
  end

  always_comb begin
    mem_wd    = mem_wd_i;
    mem_wreg  = mem_wreg_i;
    mem_wdata = mem_wdata_i;
    stallreq  = 1'b0;
    addr_err  = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (flush) begin
            mem_wreg = 1'b0;
          end else if (is_mem) begin
            mem_wreg = 1'b0;
            addr_err = misalign;
            stallreq = ~misalign;
          end
        end
        BUSY: begin
          mem_wreg = 1'b0;
          stallreq = 1'b1;
        end
        DONE: begin
          if (dbus_we || cancel || flush) mem_wreg = 1'b0;
          if (!dbus_we) mem_wdata = result;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed vector table, hand sequences, randomized ops vs. a lane-arithmetic model.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mem_wd_i;
  logic        mem_wreg_i;
  logic [31:0] mem_wdata_i;
  logic [3:0]  mem_op_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_sdata_i;
  logic        flush;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        stallreq;
  logic        addr_err;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_sel;
  logic [31:0] dbus_wdata;
  logic [31:0] dbus_rdata;
  logic        dbus_ack;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_access #(.DW(32), .RAW(5)) dut (
    .clk(clk), .rst(rst),
    .mem_wd_i(mem_wd_i), .mem_wreg_i(mem_wreg_i), .mem_wdata_i(mem_wdata_i),
    .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i), .mem_sdata_i(mem_sdata_i), .flush(flush),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .stallreq(stallreq), .addr_err(addr_err),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_sel(dbus_sel),
    .dbus_wdata(dbus_wdata), .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference model: access width in bytes and big-endian lane arithmetic.
  function automatic int nbytes(input logic [3:0] op);
    case (op)
      4'd1, 4'd2, 4'd6: return 1;
      4'd3, 4'd4, 4'd7: return 2;
      4'd5, 4'd8:       return 4;
      default:          return 0;
    endcase
  endfunction

  function automatic bit m_load(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd5);
  endfunction

  function automatic bit m_misalign(input logic [3:0] op, input logic [31:0] addr);
    int n = nbytes(op);
    return (n > 1) && ((addr % n) != 0);
  endfunction

  function automatic logic [3:0] m_sel(input logic [3:0] op, input logic [31:0] addr);
    int n = nbytes(op);
    int v = ((1 << n) - 1) << (4 - n - int'(addr % 4));
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_bwdata(input logic [3:0] op, input logic [31:0] sdata);
    int n = nbytes(op);
    logic [63:0] w = 0;
    logic [63:0] low = sdata & ((64'd1 << (8 * n)) - 1);
    for (int k = 0; k < 4 / n; k++) w = (w << (8 * n)) | low;
    return w[31:0];
  endfunction

  function automatic logic [31:0] m_load_val(input logic [3:0] op, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    int n = nbytes(op);
    logic [63:0] mask = (64'd1 << (8 * n)) - 1;
    logic [63:0] v = ({32'd0, rdata} >> (8 * (4 - n - int'(addr % 4)))) & mask;
    if ((op == 4'd1 || op == 4'd3) && v[8 * n - 1]) v = v | ~mask;
    return v[31:0];
  endfunction

  // Drives one op and checks every cycle of it. flush_cyc selects the BUSY cycle carrying flush (-1: none).
  task automatic do_op(input string nm, input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] sdata, input logic [31:0] rdata,
                       input int ack_dly, input int flush_cyc, input logic [3:0] esel,
                       input logic [31:0] ebwd, input logic [31:0] eres);
    logic [4:0]  wd  = 5'($urandom_range(1, 31));
    logic [31:0] alu = $urandom;
    bit          is_st = (op >= 4'd6) && (op <= 4'd8);
    bit          cancel = (flush_cyc >= 0) && (flush_cyc <= ack_dly);
    int          stalls;
    @(negedge clk);
    mem_op_i = op; mem_addr_i = addr; mem_sdata_i = sdata; mem_wd_i = wd;
    mem_wreg_i = 1'b1; mem_wdata_i = alu; flush = 1'b0; dbus_ack = 1'b0; dbus_rdata = rdata;
    #1;
    if (nbytes(op) == 0) begin
      chk({nm, " pass wd"}, 32'(mem_wd), 32'(wd));
      chk({nm, " pass wreg"}, 32'(mem_wreg), 32'd1);
      chk({nm, " pass wdata"}, mem_wdata, alu);
      chk({nm, " pass stall"}, 32'(stallreq), 32'd0);
      chk({nm, " pass req"}, 32'(dbus_req), 32'd0);
      return;
    end
    if (m_misalign(op, addr)) begin
      chk({nm, " addr_err"}, 32'(addr_err), 32'd1);
      chk({nm, " misal stall"}, 32'(stallreq), 32'd0);
      chk({nm, " misal wreg"}, 32'(mem_wreg), 32'd0);
      @(negedge clk);
      mem_op_i = 4'd0;
      #1;
      chk({nm, " misal req"}, 32'(dbus_req), 32'd0);
      chk({nm, " addr_err pulse"}, 32'(addr_err), 32'd0);
      return;
    end
    chk({nm, " idle stall"}, 32'(stallreq), 32'd1);
    chk({nm, " idle wreg"}, 32'(mem_wreg), 32'd0);
    stalls = 1;
    for (int c = 0; c <= ack_dly; c++) begin
      @(negedge clk);
      flush = (c == flush_cyc);
      dbus_ack = (c == ack_dly);
      #1;
      chk({nm, " busy req"}, 32'(dbus_req), 32'd1);
      chk({nm, " busy addr"}, dbus_addr, addr & ~32'd3);
      chk({nm, " busy sel"}, 32'(dbus_sel), 32'(esel));
      chk({nm, " busy we"}, 32'(dbus_we), 32'(is_st));
      if (is_st) chk({nm, " busy wdata"}, dbus_wdata, ebwd);
      if (stallreq) stalls++;
    end
    @(negedge clk);
    flush = 1'b0; dbus_ack = 1'b0;
    #1;
    chk({nm, " done stall"}, 32'(stallreq), 32'd0);
    chk({nm, " done req"}, 32'(dbus_req), 32'd0);
    chk({nm, " done wd"}, 32'(mem_wd), 32'(wd));
    chk({nm, " done wreg"}, 32'(mem_wreg), 32'(m_load(op) && !cancel));
    if (m_load(op) && !cancel) chk({nm, " done wdata"}, mem_wdata, eres);
    chk({nm, " stall cycles"}, 32'(stalls), 32'(ack_dly + 2));
  endtask

  typedef struct {
    string       nm;
    logic [3:0]  op;
    logic [31:0] addr, sdata, rdata;
    int          ack_dly, flush_cyc;
    logic [3:0]  sel;
    logic [31:0] bwd, res;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{"alu0",   4'd0,  32'h0,   32'h0,        32'h0,        0, -1, 4'b0000, 32'h0,        32'h0});
    vecs.push_back('{"lb101",  4'd1,  32'h101, 32'h0,        32'h11F23344, 1, -1, 4'b0100, 32'h0,        32'hFFFFFFF2});
    vecs.push_back('{"lbu101", 4'd2,  32'h101, 32'h0,        32'h11F23344, 0, -1, 4'b0100, 32'h0,        32'h000000F2});
    vecs.push_back('{"lb103",  4'd1,  32'h103, 32'h0,        32'h11F23344, 0, -1, 4'b0001, 32'h0,        32'h00000044});
    vecs.push_back('{"lh102",  4'd3,  32'h102, 32'h0,        32'h1122F344, 2, -1, 4'b0011, 32'h0,        32'hFFFFF344});
    vecs.push_back('{"lhu100", 4'd4,  32'h100, 32'h0,        32'h11F23344, 0, -1, 4'b1100, 32'h0,        32'h000011F2});
    vecs.push_back('{"lh100",  4'd3,  32'h100, 32'h0,        32'h81F23344, 0, -1, 4'b1100, 32'h0,        32'hFFFF81F2});
    vecs.push_back('{"lw104",  4'd5,  32'h104, 32'h0,        32'hDEADBEEF, 3, -1, 4'b1111, 32'h0,        32'hDEADBEEF});
    vecs.push_back('{"sb102",  4'd6,  32'h102, 32'h12345678, 32'h0,        1, -1, 4'b0010, 32'h78787878, 32'h0});
    vecs.push_back('{"sh202",  4'd7,  32'h202, 32'h0000ABCD, 32'h0,        0, -1, 4'b0011, 32'hABCDABCD, 32'h0});
    vecs.push_back('{"sw300",  4'd8,  32'h300, 32'hCAFEF00D, 32'h0,        1, -1, 4'b1111, 32'hCAFEF00D, 32'h0});
    vecs.push_back('{"lw103",  4'd5,  32'h103, 32'h0,        32'h0,        0, -1, 4'b0000, 32'h0,        32'h0});
    vecs.push_back('{"lh101",  4'd3,  32'h101, 32'h0,        32'h0,        0, -1, 4'b0000, 32'h0,        32'h0});
    vecs.push_back('{"sw302",  4'd8,  32'h302, 32'h0,        32'h0,        0, -1, 4'b0000, 32'h0,        32'h0});
    vecs.push_back('{"op12",   4'd12, 32'h100, 32'h0,        32'h0,        0, -1, 4'b0000, 32'h0,        32'h0});
    vecs.push_back('{"lwflush",4'd5,  32'h400, 32'h0,        32'h55667788, 2, 0,  4'b1111, 32'h0,        32'h55667788});
    vecs.push_back('{"lwafter",4'd5,  32'h404, 32'h0,        32'h01020304, 0, -1, 4'b1111, 32'h0,        32'h01020304});

    rst = 1'b1; mem_op_i = 4'd0; mem_addr_i = '0; mem_sdata_i = '0; mem_wd_i = 5'd5;
    mem_wreg_i = 1'b1; mem_wdata_i = 32'h1234; flush = 1'b0; dbus_rdata = '0; dbus_ack = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst wreg", 32'(mem_wreg), 32'd1);
    chk("rst wdata", mem_wdata, 32'h1234);
    chk("rst stall", 32'(stallreq), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst req", 32'(dbus_req), 32'd0);
    chk("rst we", 32'(dbus_we), 32'd0);
    chk("rst addr", dbus_addr, 32'h0);
    chk("rst sel", 32'(dbus_sel), 32'd0);
    chk("rst bwdata", dbus_wdata, 32'h0);
    chk("rst addr_err", 32'(addr_err), 32'd0);
    @(negedge clk);
    dbus_ack = 1'b0;
    #1;
    chk("ack in idle ignored", 32'(dbus_req) | 32'(stallreq), 32'd0);

    for (int i = 0; i < vecs.size(); i++)
      do_op(vecs[i].nm, vecs[i].op, vecs[i].addr, vecs[i].sdata, vecs[i].rdata,
            vecs[i].ack_dly, vecs[i].flush_cyc, vecs[i].sel, vecs[i].bwd, vecs[i].res);

    // Flush while IDLE: no bus cycle, write-back suppressed.
    @(negedge clk);
    mem_op_i = 4'd5; mem_addr_i = 32'h500; mem_wreg_i = 1'b1; flush = 1'b1;
    #1;
    chk("idle flush wreg", 32'(mem_wreg), 32'd0);
    chk("idle flush stall", 32'(stallreq), 32'd0);
    @(negedge clk);
    mem_op_i = 4'd0; flush = 1'b0;
    #1;
    chk("idle flush req", 32'(dbus_req), 32'd0);

    // Flush arriving in DONE.
    @(negedge clk);
    mem_op_i = 4'd5; mem_addr_i = 32'h504; dbus_rdata = 32'hA5A5A5A5;
    @(negedge clk);
    dbus_ack = 1'b1;
    @(negedge clk);
    dbus_ack = 1'b0; flush = 1'b1;
    #1;
    chk("done flush wreg", 32'(mem_wreg), 32'd0);
    chk("done flush stall", 32'(stallreq), 32'd0);
    @(negedge clk);
    mem_op_i = 4'd0; flush = 1'b0;

    // Reset in the middle of a bus cycle; the late ack must be ignored.
    @(negedge clk);
    mem_op_i = 4'd5; mem_addr_i = 32'h600; mem_wreg_i = 1'b1;
    @(negedge clk);
    #1;
    chk("rst busy req", 32'(dbus_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mem_op_i = 4'd0; dbus_ack = 1'b1; mem_wdata_i = 32'h77;
    #1;
    chk("post rst req", 32'(dbus_req), 32'd0);
    chk("post rst stall", 32'(stallreq), 32'd0);
    chk("post rst wdata", mem_wdata, 32'h77);
    @(negedge clk);
    dbus_ack = 1'b0;
    #1;
    chk("late ack req", 32'(dbus_req), 32'd0);
    chk("late ack stall", 32'(stallreq), 32'd0);
    chk("late ack wdata", mem_wdata, 32'h77);

    for (int i = 0; i < 60; i++) begin
      logic [3:0]  op    = 4'($urandom_range(0, 15));
      logic [31:0] addr  = {$urandom_range(0, 32'h3FFF), 2'($urandom_range(0, 3))};
      logic [31:0] sdata = $urandom;
      logic [31:0] rdata = $urandom;
      int          dly   = $urandom_range(0, 3);
      int          fc    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      do_op("rand", op, addr, sdata, rdata, dly, fc,
            (nbytes(op) == 0) ? 4'b0 : m_sel(op, addr),
            (nbytes(op) == 0) ? 32'h0 : m_bwdata(op, sdata),
            (nbytes(op) == 0) ? 32'h0 : m_load_val(op, addr, rdata));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter DW, default 32, data/address/register width.
REQ-002 SHALL have parameter RAW, default 5, register-file address width.
REQ-003 SHALL have ports: clk  in  1  clock, rising edge; rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: mem_wd_i  in  RAW  dest reg; mem_wreg_i  in  1  write enable; mem_wdata_i  in  DW  ALU result; mem_op_i  in  4  memory op code; mem_addr_i  in  DW  byte address; mem_sdata_i  in  DW  store data; flush  in  1  cancel current instruction.
REQ-005 SHALL have ports: mem_wd  out  RAW; mem_wreg  out  1; mem_wdata  out  DW (to MEM/WB register); stallreq  out  1  hold pipeline; addr_err  out  1  misaligned-access pulse.
REQ-006 SHALL have data-bus ports: dbus_req  out  1; dbus_we  out  1; dbus_addr  out  DW (word-aligned, low 2 bits 0); dbus_sel  out  4  byte lanes; dbus_wdata  out  DW; dbus_rdata  in  DW; dbus_ack  in  1.

Function
REQ-007 SHALL decode mem_op_i: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; codes 9-15 SHALL behave as none.
REQ-008 SHALL use big-endian lanes: byte offset 0 -> dbus_sel 1000 / bits 31:24; offset 3 -> 0001 / bits 7:0; halfword offset 0 -> 1100, offset 2 -> 0011; word -> 1111.
REQ-009 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-010 IDLE, op none: mem_wd/mem_wreg/mem_wdata SHALL equal inputs combinationally, stallreq 0, zero latency.
REQ-011 IDLE, valid-aligned memory op: stallreq SHALL be 1 combinationally, mem_wreg 0; next edge -> BUSY with dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata registered.
REQ-012 Store data SHALL be replicated to the selected lanes (SB: byte x4, SH: half x2, SW: as-is); dbus_we 1 for stores, 0 for loads.
REQ-013 BUSY: dbus_req and all bus outputs SHALL hold stable, stallreq 1, until dbus_ack sampled 1 at an edge; at that edge dbus_req SHALL drop and state -> DONE.
REQ-014 On the ack edge a load SHALL capture the selected lane(s), sign-extended (LB, LH) or zero-extended (LBU, LHU), into a result register; dbus_ack while not BUSY SHALL be ignored.
REQ-015 DONE: stallreq SHALL be 0; mem_wd = mem_wd_i; load -> mem_wreg = mem_wreg_i, mem_wdata = result; store -> mem_wreg 0; next edge -> IDLE unconditionally.
REQ-016 Misalignment (LH/LHU/SH addr[0]=1; LW/SW addr[1:0]!=0) in IDLE SHALL produce no bus cycle, stallreq 0, mem_wreg 0, addr_err 1 for that cycle only; addr_err SHALL be 0 otherwise.
REQ-017 flush in BUSY SHALL NOT abort the bus cycle; it SHALL set a sticky cancel bit so DONE outputs mem_wreg 0; cancel bit clears on entry to IDLE.
REQ-018 flush in IDLE or DONE SHALL force mem_wreg 0 that cycle and start no bus cycle.
REQ-019 Back-to-back memory ops SHALL each take IDLE -> BUSY -> DONE; minimum 3 cycles per op with same-cycle-after-request ack.

Reset
REQ-020 rst sampled 1 SHALL set state IDLE, dbus_req 0, dbus_we 0, dbus_addr 0, dbus_sel 0, dbus_wdata 0, result 0, cancel 0, at that edge, from any state including BUSY.
REQ-021 During and after reset with mem_op_i none, mem_wreg/mem_wd/mem_wdata SHALL follow inputs, stallreq 0, addr_err 0; a pending ack after reset SHALL be ignored.

Verification
REQ-022 ALU pass-through: op 0, wd 5, wreg 1, wdata 0x1234 -> same cycle mem_wd 5, mem_wreg 1, mem_wdata 0x1234, stallreq 0, dbus_req 0.
REQ-023 LB addr 0x101, rdata 0x11F23344, ack after 2 BUSY cycles -> dbus_addr 0x100, sel 0100, stallreq 1 for 3 cycles, DONE mem_wdata 0xFFFFFFF2.
REQ-024 SH addr 0x202, sdata 0x0000ABCD, ack first BUSY cycle -> dbus_we 1, sel 0011, wdata 0xABCDABCD, DONE mem_wreg 0.
REQ-025 LW addr 0x103 -> addr_err 1 one cycle, dbus_req never 1, mem_wreg 0, stallreq 0.
REQ-026 LW in BUSY, flush 1 one cycle, ack later -> bus cycle completes, DONE mem_wreg 0; next LW completes normally with mem_wreg 1.
REQ-027 rst 1 during BUSY -> next cycle IDLE, dbus_req 0, stallreq 0; late ack ignored, no write-back.
